// File: rtl/common.sv
// Operand descriptor kinds and the issue queue entry layout.
package common;

    typedef enum logic [1:0] {
        ZERO,
        REG,
        IMM,
        PC
    } op_type_t;

    typedef struct packed {
        logic        busy;
        op_type_t    op1_type;
        op_type_t    op2_type;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        op1_valid;
        logic        op2_valid;
        logic [31:0] payload;
    } iq_entry_t;

endpackage

// File: rtl/parameters.sv
// Build-wide sizing constants shared by the dispatch and issue stages.
package parameters;

    localparam int unsigned DISPATCH_WIDTH       = 2;
    localparam int unsigned PHYS_REGS_ADDR_WIDTH = 6;
    localparam int unsigned IQ_DEPTH             = 8;
    localparam int unsigned WB_WIDTH             = 2;

endpackage

// File: rtl/iq_wakeup_cmp.sv
// Matches one operand's phys tag against all writeback broadcasts and returns its
// updated ready bit; only REG operands can be woken.
module iq_wakeup_cmp
    import common::*;
    import parameters::PHYS_REGS_ADDR_WIDTH;
#(
    parameter int unsigned WB_WIDTH = parameters::WB_WIDTH
) (
    input  op_type_t                        op_type,
    input  logic [PHYS_REGS_ADDR_WIDTH-1:0] tag,
    input  logic                            op_valid,
    input  logic                            wb_valid [WB_WIDTH],
    input  logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_tag   [WB_WIDTH],
    output logic                            woken
);

    logic hit;

    always_comb begin
        hit = 1'b0;
        for (int unsigned k = 0; k < WB_WIDTH; k++) begin
            hit = hit | (wb_valid[k] && (wb_tag[k] == tag));
        end
    end

    assign woken = op_valid | ((op_type == REG) && hit);

endmodule

// File: rtl/issue_queue_wakeup.sv
// Collapsing issue queue: holds dispatched ops until both operands are ready by snooping
// writeback tags, then issues the oldest ready entry over a valid/ready handshake.
module issue_queue_wakeup
    import common::*;
    import parameters::DISPATCH_WIDTH;
    import parameters::PHYS_REGS_ADDR_WIDTH;
#(
    parameter int unsigned IQ_DEPTH = parameters::IQ_DEPTH,
    parameter int unsigned WB_WIDTH = parameters::WB_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            dispatch_valid [DISPATCH_WIDTH],
    output logic                            dispatch_ready,
    input  op_type_t                        op1_type       [DISPATCH_WIDTH],
    input  op_type_t                        op2_type       [DISPATCH_WIDTH],
    input  logic [31:0]                     op1            [DISPATCH_WIDTH],
    input  logic [31:0]                     op2            [DISPATCH_WIDTH],
    input  logic                            op1_valid      [DISPATCH_WIDTH],
    input  logic                            op2_valid      [DISPATCH_WIDTH],
    input  logic [31:0]                     payload        [DISPATCH_WIDTH],
    input  logic                            wb_valid       [WB_WIDTH],
    input  logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_tag         [WB_WIDTH],
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output op_type_t                        issue_op1_type,
    output op_type_t                        issue_op2_type,
    output logic [31:0]                     issue_op1,
    output logic [31:0]                     issue_op2,
    output logic [31:0]                     issue_payload
);

    localparam int unsigned CntW = $clog2(IQ_DEPTH + 1);
    localparam int unsigned IdxW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;

    iq_entry_t entries_q [IQ_DEPTH];
    iq_entry_t entries_d [IQ_DEPTH];
    iq_entry_t woken     [IQ_DEPTH + 1];
    iq_entry_t incoming  [DISPATCH_WIDTH];

    logic [IQ_DEPTH-1:0]       s1_valid, s2_valid;
    logic [DISPATCH_WIDTH-1:0] d1_valid, d2_valid;
    logic [CntW-1:0]           count, slot;
    logic [IdxW-1:0]           sel_idx;
    logic                      sel_found, do_issue, any_dispatch;

    for (genvar i = 0; i < IQ_DEPTH; i++) begin : g_entry
        iq_wakeup_cmp #(.WB_WIDTH(WB_WIDTH)) u_cmp1 (
            .op_type (entries_q[i].op1_type),
            .tag     (entries_q[i].op1[PHYS_REGS_ADDR_WIDTH-1:0]),
            .op_valid(entries_q[i].op1_valid),
            .wb_valid(wb_valid),
            .wb_tag  (wb_tag),
            .woken   (s1_valid[i])
        );
        iq_wakeup_cmp #(.WB_WIDTH(WB_WIDTH)) u_cmp2 (
            .op_type (entries_q[i].op2_type),
            .tag     (entries_q[i].op2[PHYS_REGS_ADDR_WIDTH-1:0]),
            .op_valid(entries_q[i].op2_valid),
            .wb_valid(wb_valid),
            .wb_tag  (wb_tag),
            .woken   (s2_valid[i])
        );
    end

    // Incoming operands also see this cycle's broadcasts so no wakeup slips past dispatch.
    for (genvar b = 0; b < DISPATCH_WIDTH; b++) begin : g_bank
        iq_wakeup_cmp #(.WB_WIDTH(WB_WIDTH)) u_cmp1 (
            .op_type (op1_type[b]),
            .tag     (op1[b][PHYS_REGS_ADDR_WIDTH-1:0]),
            .op_valid(op1_valid[b]),
            .wb_valid(wb_valid),
            .wb_tag  (wb_tag),
            .woken   (d1_valid[b])
        );
        iq_wakeup_cmp #(.WB_WIDTH(WB_WIDTH)) u_cmp2 (
            .op_type (op2_type[b]),
            .tag     (op2[b][PHYS_REGS_ADDR_WIDTH-1:0]),
            .op_valid(op2_valid[b]),
            .wb_valid(wb_valid),
            .wb_tag  (wb_tag),
            .woken   (d2_valid[b])
        );
    end

    // Occupancy and oldest-ready select, both from registered state only.
    always_comb begin
        count     = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
            count = count + CntW'(entries_q[i].busy);
            if (!sel_found && entries_q[i].busy && entries_q[i].op1_valid &&
                entries_q[i].op2_valid) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(i);
            end
        end
    end

    assign dispatch_ready = (count <= CntW'(IQ_DEPTH - DISPATCH_WIDTH));
    assign issue_valid    = sel_found;

    always_comb begin
        issue_op1_type = ZERO;
        issue_op2_type = ZERO;
        issue_op1      = '0;
        issue_op2      = '0;
        issue_payload  = '0;
        for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
            if (sel_found && (sel_idx == IdxW'(i))) begin
                issue_op1_type = entries_q[i].op1_type;
                issue_op2_type = entries_q[i].op2_type;
                issue_op1      = entries_q[i].op1;
                issue_op2      = entries_q[i].op2;
                issue_payload  = entries_q[i].payload;
            end
        end
    end

    always_comb begin
        any_dispatch = 1'b0;
        for (int unsigned b = 0; b < DISPATCH_WIDTH; b++) begin
            any_dispatch = any_dispatch | dispatch_valid[b];
            incoming[b].busy      = 1'b1;
            incoming[b].op1_type  = op1_type[b];
            incoming[b].op2_type  = op2_type[b];
            incoming[b].op1       = op1[b];
            incoming[b].op2       = op2[b];
            incoming[b].op1_valid = d1_valid[b];
            incoming[b].op2_valid = d2_valid[b];
            incoming[b].payload   = payload[b];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
            woken[i]           = entries_q[i];
            woken[i].op1_valid = s1_valid[i];
            woken[i].op2_valid = s2_valid[i];
        end
        woken[IQ_DEPTH] = '0;
        do_issue = sel_found & issue_ready;

        // Entries above the issued slot slide down one; the top refills with an empty entry.
        for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
            if (do_issue && (i >= 32'(sel_idx))) begin
                entries_d[i] = woken[i + 1];
            end else begin
                entries_d[i] = woken[i];
            end
        end

        slot = count - CntW'(do_issue);
        for (int unsigned b = 0; b < DISPATCH_WIDTH; b++) begin
            if (dispatch_ready && dispatch_valid[b]) begin
                for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
                    if (slot == CntW'(i)) begin
                        entries_d[i] = incoming[b];
                    end
                end
                slot = slot + CntW'(1);
            end
        end

        if (flush) begin
            for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
                entries_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

    a_dispatch_when_ready: assert property (
        @(posedge clk) disable iff (!rst_n) any_dispatch |-> dispatch_ready
    );

endmodule

// File: tb/tb_issue_queue_wakeup.sv
// Randomized and directed bench for issue_queue_wakeup with a queue-based reference model
// and a scoreboard fed by the stimulus side and drained by an issue monitor.
module tb_issue_queue_wakeup;
    import common::*;

    localparam int DW    = parameters::DISPATCH_WIDTH;
    localparam int PW    = parameters::PHYS_REGS_ADDR_WIDTH;
    localparam int DEPTH = parameters::IQ_DEPTH;
    localparam int WBW   = parameters::WB_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          dispatch_valid [DW];
    logic          dispatch_ready;
    op_type_t      op1_type [DW];
    op_type_t      op2_type [DW];
    logic [31:0]   op1 [DW];
    logic [31:0]   op2 [DW];
    logic          op1_valid [DW];
    logic          op2_valid [DW];
    logic [31:0]   payload [DW];
    logic          wb_valid [WBW];
    logic [PW-1:0] wb_tag [WBW];
    logic          issue_valid;
    logic          issue_ready;
    op_type_t      issue_op1_type, issue_op2_type;
    logic [31:0]   issue_op1, issue_op2, issue_payload;

    always #5 clk = ~clk;

    issue_queue_wakeup dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .dispatch_valid(dispatch_valid),
        .dispatch_ready(dispatch_ready),
        .op1_type      (op1_type),
        .op2_type      (op2_type),
        .op1           (op1),
        .op2           (op2),
        .op1_valid     (op1_valid),
        .op2_valid     (op2_valid),
        .payload       (payload),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_op1_type(issue_op1_type),
        .issue_op2_type(issue_op2_type),
        .issue_op1     (issue_op1),
        .issue_op2     (issue_op2),
        .issue_payload (issue_payload)
    );

    typedef struct {
        op_type_t    t1, t2;
        logic [31:0] o1, o2;
        bit          v1, v2;
        logic [31:0] pl;
    } m_entry_t;

    m_entry_t    model [$];
    m_entry_t    exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned pl_ctr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        flush = 1'b0;
        for (int b = 0; b < DW; b++) begin
            dispatch_valid[b] = 1'b0;
            op1_type[b] = ZERO;
            op2_type[b] = ZERO;
            op1[b] = '0;
            op2[b] = '0;
            op1_valid[b] = 1'b0;
            op2_valid[b] = 1'b0;
            payload[b] = '0;
        end
        for (int k = 0; k < WBW; k++) begin
            wb_valid[k] = 1'b0;
            wb_tag[k] = '0;
        end
    endtask

    task automatic set_bank(input int b, input op_type_t t1, input logic [31:0] o1, input bit v1,
                            input op_type_t t2, input logic [31:0] o2, input bit v2);
        dispatch_valid[b] = 1'b1;
        op1_type[b] = t1;
        op2_type[b] = t2;
        op1[b] = o1;
        op2[b] = o2;
        op1_valid[b] = v1;
        op2_valid[b] = v2;
        payload[b] = 32'h1000 + pl_ctr;
        pl_ctr++;
    endtask

    function automatic bit tag_hit(input logic [31:0] op);
        for (int k = 0; k < WBW; k++) begin
            if (wb_valid[k] && (wb_tag[k] == op[PW-1:0])) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int model_sel();
        for (int i = 0; i < model.size(); i++) begin
            if (model[i].v1 && model[i].v2) return i;
        end
        return -1;
    endfunction

    // Advance the reference queue by one clock edge using the inputs held this cycle.
    task automatic model_step(input int sel);
        bit       rdy;
        m_entry_t e;
        if (flush) begin
            model.delete();
        end else begin
            rdy = (model.size() <= DEPTH - DW);
            if (sel >= 0 && issue_ready) model.delete(sel);
            foreach (model[i]) begin
                if (model[i].t1 == REG && tag_hit(model[i].o1)) model[i].v1 = 1'b1;
                if (model[i].t2 == REG && tag_hit(model[i].o2)) model[i].v2 = 1'b1;
            end
            if (rdy) begin
                for (int b = 0; b < DW; b++) begin
                    if (dispatch_valid[b]) begin
                        e.t1 = op1_type[b];
                        e.t2 = op2_type[b];
                        e.o1 = op1[b];
                        e.o2 = op2[b];
                        e.v1 = op1_valid[b] || (op1_type[b] == REG && tag_hit(op1[b]));
                        e.v2 = op2_valid[b] || (op2_type[b] == REG && tag_hit(op2[b]));
                        e.pl = payload[b];
                        model.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        int sel;
        @(negedge clk);
        sel = model_sel();
        check("issue_valid", 32'(issue_valid), 32'(sel >= 0));
        check("dispatch_ready", 32'(dispatch_ready), 32'(model.size() <= DEPTH - DW));
        if (sel >= 0) begin
            check("selected_payload", issue_payload, model[sel].pl);
            if (issue_ready) exp_q.push_back(model[sel]);
        end else begin
            check("idle_fields_zero", issue_op1 | issue_op2 | issue_payload, 32'h0);
        end
        @(posedge clk);
        model_step(sel);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        check("reset_issue_valid", 32'(issue_valid), 32'h0);
        check("reset_dispatch_ready", 32'(dispatch_ready), 32'h1);
        model.delete();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted issue must match the oldest outstanding expectation.
    initial begin
        m_entry_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && issue_valid && issue_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", issue_payload, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_payload", issue_payload, e.pl);
                    check("issue_op1", issue_op1, e.o1);
                    check("issue_op2", issue_op2, e.o2);
                    check("issue_types", {28'h0, issue_op1_type, issue_op2_type},
                          {28'h0, e.t1, e.t2});
                end
            end
        end
    end

    initial begin
        issue_ready = 1'b1;
        apply_reset();

        // Immediate operands issue the cycle after dispatch.
        set_bank(0, IMM, 5, 1'b1, IMM, 7, 1'b1);
        cycle();
        clear_inputs();
        cycle();

        // Waiting register operand woken by a later broadcast.
        set_bank(0, IMM, 1, 1'b1, REG, 12, 1'b0);
        cycle();
        clear_inputs();
        repeat (5) cycle();
        wb_valid[0] = 1'b1;
        wb_tag[0] = 6'd12;
        cycle();
        clear_inputs();
        cycle();

        // Broadcast in the dispatch cycle itself.
        set_bank(0, IMM, 0, 1'b1, REG, 3, 1'b0);
        wb_valid[1] = 1'b1;
        wb_tag[1] = 6'd3;
        cycle();
        clear_inputs();
        cycle();

        // Younger ready entry bypasses an older waiting one.
        set_bank(0, REG, 9, 1'b0, IMM, 2, 1'b1);
        cycle();
        clear_inputs();
        set_bank(0, IMM, 4, 1'b1, IMM, 6, 1'b1);
        cycle();
        clear_inputs();
        cycle();
        wb_valid[0] = 1'b1;
        wb_tag[0] = 6'd9;
        cycle();
        clear_inputs();
        repeat (2) cycle();

        // Fill to 7 with one ready entry under backpressure, then drain.
        issue_ready = 1'b0;
        repeat (3) begin
            set_bank(0, REG, 20, 1'b0, IMM, 0, 1'b1);
            set_bank(1, IMM, 0, 1'b1, REG, 20, 1'b0);
            cycle();
            clear_inputs();
        end
        set_bank(0, IMM, 11, 1'b1, IMM, 13, 1'b1);
        cycle();
        clear_inputs();
        repeat (4) cycle();
        issue_ready = 1'b1;
        cycle();
        wb_valid[1] = 1'b1;
        wb_tag[1] = 6'd20;
        cycle();
        clear_inputs();
        repeat (8) cycle();

        // Flush dominates a simultaneous dispatch.
        issue_ready = 1'b0;
        repeat (2) begin
            set_bank(0, REG, 21, 1'b0, IMM, 0, 1'b1);
            set_bank(1, REG, 21, 1'b0, REG, 22, 1'b0);
            cycle();
            clear_inputs();
        end
        flush = 1'b1;
        set_bank(0, IMM, 1, 1'b1, IMM, 2, 1'b1);
        set_bank(1, IMM, 3, 1'b1, IMM, 4, 1'b1);
        cycle();
        clear_inputs();
        repeat (2) cycle();

        // Asynchronous reset in the middle of operation.
        set_bank(0, IMM, 8, 1'b1, IMM, 9, 1'b1);
        set_bank(1, REG, 5, 1'b0, IMM, 9, 1'b1);
        cycle();
        clear_inputs();
        apply_reset();
        issue_ready = 1'b1;
        repeat (2) cycle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            flush = ($urandom_range(0, 49) == 0);
            issue_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < WBW; k++) begin
                wb_valid[k] = $urandom_range(0, 1);
                wb_tag[k] = PW'($urandom_range(0, 7));
            end
            if (model.size() <= DEPTH - DW) begin
                for (int b = 0; b < DW; b++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        op_type_t    t1, t2;
                        logic [31:0] o1, o2;
                        bit          v1, v2;
                        t1 = ($urandom_range(0, 4) < 3) ? REG : IMM;
                        t2 = ($urandom_range(0, 4) < 3) ? REG : IMM;
                        o1 = (t1 == REG) ? 32'($urandom_range(0, 7)) : 32'($urandom);
                        o2 = (t2 == REG) ? 32'($urandom_range(0, 7)) : 32'($urandom);
                        v1 = (t1 == REG) ? ($urandom_range(0, 2) == 0) : 1'b1;
                        v2 = (t2 == REG) ? ($urandom_range(0, 2) == 0) : 1'b1;
                        set_bank(b, t1, o1, v1, t2, o2, v2);
                    end
                end
            end
            cycle();
        end

        clear_inputs();
        issue_ready = 1'b1;
        repeat (2) cycle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
